// File: rtl/demux_stream_scheduler.sv
// Single-slot stream demux: routes each accepted beat to one output lane,
// either by a per-beat destination (addressed) or by round-robin over enabled lanes.
module demux_stream_scheduler #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [NUM_OUT-1:0] en_mask,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]   in_dest,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic [7:0]         drop_cnt
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [SEL_W-1:0]   rr_last_q, rr_last_d;

  logic               occ_c;
  logic               rel_c;
  logic               acc_c;
  logic [SEL_W-1:0]   tgt_c;
  logic               tgt_ok_c;
  logic [SEL_W-1:0]   rr_tgt_c;
  logic               rr_hit_c;
  logic [SEL_W-1:0]   idx_c;

  assign occ_c    = (state_q == S_HOLD);
  assign rel_c    = occ_c && out_ready[sel_q];
  assign in_ready = !occ_c || rel_c;
  assign acc_c    = in_valid && in_ready;

  // Round-robin search starts just after rr_last and checks rr_last itself last.
  always_comb begin
    rr_tgt_c = '0;
    rr_hit_c = 1'b0;
    idx_c    = '0;
    for (int unsigned k = 1; k <= NUM_OUT; k++) begin
      idx_c = SEL_W'(rr_last_q + SEL_W'(k));
      if (!rr_hit_c && en_mask[idx_c]) begin
        rr_tgt_c = idx_c;
        rr_hit_c = 1'b1;
      end
    end
  end

  always_comb begin
    tgt_c    = mode ? rr_tgt_c : in_dest;
    tgt_ok_c = mode ? rr_hit_c : en_mask[in_dest];
  end

  // Slot next-state: a loading accept wins over release so back-to-back beats have no bubble.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    drop_d    = drop_q;
    rr_last_d = rr_last_q;
    if (acc_c && tgt_ok_c) begin
      state_d = S_HOLD;
      sel_d   = tgt_c;
      data_d  = in_data;
      if (mode) begin
        rr_last_d = tgt_c;
      end
    end else if (rel_c) begin
      state_d = S_IDLE;
      data_d  = '0;
    end
    if (acc_c && !tgt_ok_c && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      data_q    <= '0;
      drop_q    <= '0;
      rr_last_q <= SEL_W'(NUM_OUT - 1);
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      drop_q    <= drop_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign out_valid = occ_c ? (NUM_OUT'(1) << sel_q) : '0;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_stream_scheduler.sv
// Scoreboard bench: the driver queues expected (lane, data) per loaded beat;
// a negedge monitor pops and compares on every completed output handshake.
module tb_demux_stream_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [3:0] en_mask;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic [7:0] drop_cnt;

  int applied = 0;
  int miscompares = 0;
  int stalls = 0;
  bit any_valid = 1'b0;
  logic [9:0] exp_q[$];

  demux_stream_scheduler #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en_mask(en_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid != 4'b0) begin
      any_valid = 1'b1;
      if (out_ready[out_sel]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {22'b0, out_sel, out_data}, 32'hFFFF_FFFF);
        end else begin
          logic [9:0] e;
          logic [3:0] ev;
          e = exp_q.pop_front();
          ev = 4'b0001 << e[9:8];
          chk("out_lane_data", {22'b0, out_sel, out_data}, {22'b0, e});
          chk("out_valid_onehot", {28'b0, out_valid}, {28'b0, ev});
        end
      end
    end
  end

  task automatic send(input logic [1:0] d, input logic [7:0] v, input bit push,
                      input logic [1:0] lane);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    in_dest  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    if (push) exp_q.push_back({lane, v});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; en_mask = 4'hF; in_valid = 1'b0;
    in_data = 8'h00; in_dest = 2'd0; out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1. reset state
    @(negedge clk);
    chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
    chk("rst_out_data", {24'b0, out_data}, 32'h0);
    chk("rst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // 2. addressed routing, back to back
    stalls = 0;
    send(2'd2, 8'hA5, 1'b1, 2'd2);
    send(2'd0, 8'h3C, 1'b1, 2'd0);
    chk("addr_no_stall", stalls, 32'd0);
    drain();

    // 3. round-robin skipping disabled lane 2
    mode = 1'b1; en_mask = 4'b1011;
    send(2'd0, 8'h01, 1'b1, 2'd0);
    send(2'd0, 8'h02, 1'b1, 2'd1);
    send(2'd0, 8'h03, 1'b1, 2'd3);
    send(2'd0, 8'h04, 1'b1, 2'd0);
    send(2'd0, 8'h05, 1'b1, 2'd1);
    drain();

    // 4. backpressure on lane 1, other lanes' ready ignored
    mode = 1'b0; en_mask = 4'hF; out_ready = 4'b1101;
    send(2'd1, 8'h77, 1'b1, 2'd1);
    in_valid = 1'b1; in_data = 8'h88; in_dest = 2'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      chk("bp_out_data", {24'b0, out_data}, 32'h77);
      chk("bp_out_valid", {28'b0, out_valid}, 32'b0010);
      @(posedge clk);
      #1;
    end
    out_ready = 4'hF;
    @(negedge clk);
    chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
    exp_q.push_back({2'd2, 8'h88});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_bubble", {28'b0, out_valid}, 32'b0100);
    drain();

    // 5. drops to a disabled lane, saturating counter
    en_mask = 4'b1110;
    any_valid = 1'b0;
    for (int b = 0; b < 300; b++) begin
      send(2'd0, 8'(b), 1'b0, 2'd0);
      if (b == 9) chk("drop_cnt_10", {24'b0, drop_cnt}, 32'd10);
    end
    @(negedge clk);
    chk("drop_no_valid", {31'b0, any_valid}, 32'h0);
    chk("drop_sat", {24'b0, drop_cnt}, 32'hFF);
    @(posedge clk);
    #1;

    // 6. reset while holding; rr_last is 1 so the held beat sits on lane 2
    mode = 1'b1; en_mask = 4'hF; out_ready = 4'h0;
    send(2'd0, 8'h55, 1'b0, 2'd2);
    @(negedge clk);
    chk("hold_before_rst", {28'b0, out_valid}, 32'b0100);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {28'b0, out_valid}, 32'h0);
    chk("midrst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    send(2'd3, 8'h66, 1'b1, 2'd0);
    drain();

    // round-robin with nothing enabled drops each beat
    en_mask = 4'h0;
    any_valid = 1'b0;
    for (int b = 0; b < 3; b++) send(2'd1, 8'hC0, 1'b0, 2'd0);
    @(negedge clk);
    chk("rr_empty_drops", {24'b0, drop_cnt}, 32'd3);
    chk("rr_empty_no_valid", {31'b0, any_valid}, 32'h0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/demux_stream_scheduler.md
Name: demux_stream_scheduler

Overview:
- Routes one input stream to one of NUM_OUT output lanes using a valid/ready handshake.
- Two routing modes: addressed (lane taken from a per-beat destination field) and round-robin (lanes taken in turn, skipping disabled lanes).
- A single registered output slot gives 1-cycle latency and full throughput.
- Beats addressed to a disabled lane are dropped and counted.
- Sits between a producer and the per-lane demux datapath, and sequences which lane owns the shared output data bus.

Parameters:
- DATA_W, 8, payload width.
- NUM_OUT, 4, number of output lanes; power of two, at least 2.
- SEL_W, 2, lane index width; equals log2(NUM_OUT).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mode  in  1  0 = addressed, 1 = round-robin.
- en_mask  in  NUM_OUT  per-lane enable; bit i = 1 means lane i may receive beats.
- in_valid  in  1  input beat present.
- in_ready  out  1  scheduler can accept a beat this cycle.
- in_data  in  DATA_W  input payload.
- in_dest  in  SEL_W  target lane; used only when mode = 0.
- out_valid  out  NUM_OUT  one-hot (or zero) lane valid.
- out_ready  in  NUM_OUT  per-lane ready.
- out_data  out  DATA_W  shared payload bus for the selected lane.
- out_sel  out  SEL_W  index of the lane currently holding the slot.
- drop_cnt  out  8  saturating count of dropped beats.

Behaviour:
- Reset (rst_n = 0 at a clk edge) sets:
  - occ = 0, out_valid = 0, out_data = 0, out_sel = 0
  - drop_cnt = 0
  - rr_last = NUM_OUT-1, so the first round-robin grant goes to lane 0.
  - Reset mid-transfer discards the held beat; it is not counted as a drop.
- Slot state is HOLD when occ = 1 and IDLE when occ = 0.
- out_valid[i] = occ && (out_sel == i). At most one bit is ever set.
- out_data = 0 whenever occ = 0 (idle-low demux convention).
- Release: rel = occ && out_ready[out_sel].
- Input handshake: in_ready = !occ || rel. This is combinational on out_ready; there is no combinational path from in_valid.
- A beat is accepted on a cycle with acc = in_valid && in_ready.
- mode, en_mask and in_dest are sampled only at acc. Changing them while in HOLD does not affect the held beat.
- Lane target computed at acc:
  - mode = 0: tgt = in_dest; the target is valid iff en_mask[in_dest] = 1.
  - mode = 1: tgt = first i with en_mask[i] = 1, searching from rr_last+1 upward and wrapping modulo NUM_OUT. rr_last itself is checked last, so a single enabled lane is granted repeatedly. The target is valid iff en_mask != 0.
- On acc with a valid target, at the next edge:
  - occ = 1, out_sel = tgt, out_data = in_data.
  - In mode 1, rr_last = tgt.
- On acc with an invalid target:
  - The beat is consumed (in_ready was high) and not loaded.
  - drop_cnt increments, saturating at 8'hFF.
  - rr_last is unchanged.
  - occ = 0 after this edge if rel was set this cycle; otherwise occ is unchanged.
- On rel without a loading acc: occ = 0 and out_data = 0 at the next edge.
- Simultaneous rel and loading acc: the slot is reloaded with the new beat. This is back-to-back with no bubble, so throughput is 1 beat/cycle.
- Latency: in_data at an acc edge appears on out_data/out_valid 1 cycle later.
- Held data stays stable while out_valid is high and out_ready is low.
- out_ready of lanes other than out_sel is ignored.
- Mode switches take effect on the next acc. rr_last is retained across mode switches.

Test Plan:
1. Reset then idle:
   - After reset: out_valid = 0, out_data = 0, drop_cnt = 0, in_ready = 1.
2. Addressed routing:
   - mode = 0, en_mask = 4'hF, all out_ready = 1.
   - Beats (dest, data) = (2, 8'hA5), (0, 8'h3C) on consecutive cycles.
   - Required: out_valid = 4'b0100 / out_data = 8'hA5, then 4'b0001 / 8'h3C on the next cycle; in_ready stays 1.
3. Round-robin with skip:
   - mode = 1, en_mask = 4'b1011, 5 beats 8'h01..8'h05 with all out_ready = 1.
   - Required grant sequence: lanes 0, 1, 3, 0, 1.
4. Backpressure:
   - Hold beat 8'h77 on lane 1 with out_ready[1] = 0 for 3 cycles; out_ready[0] = 1 throughout.
   - Required: in_ready = 0, out_data = 8'h77 stable, out_valid = 4'b0010.
   - Then raise out_ready[1] with in_valid high: the next beat loads with no bubble cycle.
5. Drop and saturate:
   - mode = 0, en_mask = 4'b1110, 300 beats to dest 0.
   - Required: no out_valid ever set; drop_cnt ends at 8'hFF.
   - Also: mode = 1 with en_mask = 0 drops and counts each beat.
6. Reset mid-HOLD:
   - Assert rst_n = 0 for 1 cycle while a beat is held.
   - Required: out_valid = 0 and drop_cnt = 0 next cycle; the next round-robin grant is lane 0.
